dm_result_checker: RTL and testbench
====================================

// Module: dm_result_checker
// PURPOSE
//  Synthesizable end-of-test checker that sits beside data memory (DM) in top.
//  It snoops DM writes for the end-of-simulation sentinel, or times out after MAX_CYCLES.
//  It then reads back NUM_WORDS words from TEST_START, compares each against a golden ROM,
//  and reports the error count, the first failing index, and pass/fail.
// PARAMETERS
//  ADDR_W      16            DM word-address width
//  DATA_W      32            DM / golden data width
//  END_ADDR    16'h3fff      sentinel word address
//  END_CODE    {DATA_W{1'b1}} sentinel value (-1)
//  TEST_START  16'h2000      first checked DM word address
//  NUM_WORDS   64            words checked (>=1); IDX_W=$clog2(NUM_WORDS), ERR_W=$clog2(NUM_WORDS+1)
//  MAX_CYCLES  100000        watchdog limit in RUN cycles (>=2)
//  CNT_W       17            watchdog counter width, must hold MAX_CYCLES
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low
//  clear        in   1       sync restart: back to RUN, all status cleared
//  dm_web       in   4       DM byte write enables (1 = write byte)
//  dm_addr      in   ADDR_W  DM write word address (snooped)
//  dm_di        in   DATA_W  DM write data (snooped)
//  chk_re       out  1       read strobe to DM check port / golden ROM
//  chk_addr     out  ADDR_W  DM check-port address = TEST_START+idx
//  gold_addr    out  IDX_W   golden ROM index = idx
//  chk_rdata    in   DATA_W  DM read data, valid 1 cycle after chk_re
//  gold_rdata   in   DATA_W  golden data, valid 1 cycle after chk_re
//  busy         out  1       high in CHECK
//  done         out  1       high in DONE
//  pass         out  1       done & err_cnt==0 & !timeout
//  timeout      out  1       watchdog expired before sentinel
//  err_cnt      out  ERR_W   mismatching words
//  first_err    out  IDX_W   index of first mismatch (0 if none)
// BEHAVIOUR
//  Reset: state=RUN; every output 0; cycle counter, idx, and compare-valid flag all 0.
//  States: RUN -> CHECK -> DONE. DONE holds until rst low or clear.
//  RUN: the cycle counter increments every cycle.
//   Sentinel hit = dm_web==4'hF & dm_addr==END_ADDR & dm_di==END_CODE. A partial-byte write never hits.
//   On a sentinel hit: next state CHECK, idx=0, timeout stays 0.
//   Else if counter==MAX_CYCLES-1: next state CHECK, timeout<=1.
//   Hit and expiry in the same cycle: the hit wins, timeout=0.
//  CHECK, pipelined with 1-cycle read latency:
//   Cycle k (0..NUM_WORDS-1): chk_re=1, idx=k. Compare-valid is set for cycle k+1.
//   Cycle k+1: if chk_rdata!=gold_rdata, err_cnt++. first_err<=k on the first mismatch only.
//   After the last compare (NUM_WORDS+1 cycles after entry): state DONE. No stalls.
//  DONE: done=1; pass as defined above; chk_re=0. err_cnt, first_err and timeout are frozen.
//  clear (any state): next cycle = reset state except rst is not asserted.
//   clear beats a same-cycle sentinel hit or watchdog expiry.
//   clear during CHECK abandons the scan; the partial err_cnt is discarded.
//  rst low mid-CHECK: immediate async return to the reset state.
//  dm_web/dm_addr/dm_di are ignored outside RUN; a second sentinel write has no effect.
//  err_cnt never exceeds NUM_WORDS, so no wrap is possible.
//   The watchdog counter stops at MAX_CYCLES-1 and does not wrap.
//  All outputs are registered except chk_re, chk_addr and gold_addr, which decode from state/idx.
// TESTING
//  1 Golden ROM == DM contents; sentinel write at cycle 50 -> busy 65 cycles, done, pass=1, err_cnt=0.
//  2 DM words idx 3 and 40 corrupted -> err_cnt=2, first_err=3, pass=0.
//  3 No sentinel, MAX_CYCLES=200 -> timeout=1 after 200 cycles; check still runs; pass=0 even with 0 errors.
//  4 Writes to END_ADDR with dm_web=4'h3 or data 32'h0 -> no trigger; a full -1 write then triggers.
//  5 clear at CHECK idx=10 with 1 error so far -> RUN, err_cnt=0; rerun with a clean DM gives pass=1.
//  6 rst low at CHECK idx=20 -> all outputs 0 asynchronously; recovery into RUN on release.

Source files
------------

// File: rtl/dm_result_checker_if.sv
// Bundles the DM write snoop port and the DM/golden-ROM check read port.
// slave = the checker, master = the surrounding top / memories.
interface dm_result_checker_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic [3:0]        dm_web;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_di;
    logic              chk_re;
    logic [ADDR_W-1:0] chk_addr;
    logic [IDX_W-1:0]  gold_addr;
    logic [DATA_W-1:0] chk_rdata;
    logic [DATA_W-1:0] gold_rdata;

    modport slave (
        input  dm_web, dm_addr, dm_di, chk_rdata, gold_rdata,
        output chk_re, chk_addr, gold_addr
    );
    modport master (
        output dm_web, dm_addr, dm_di, chk_rdata, gold_rdata,
        input  chk_re, chk_addr, gold_addr
    );
endinterface

// File: rtl/dm_result_checker.sv
// End-of-test checker: waits for the DM sentinel write (or watchdog), then scans
// NUM_WORDS DM words against a golden ROM and reports error count / first error / pass.
module dm_result_checker #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] END_ADDR   = 16'h3fff,
    parameter logic [DATA_W-1:0] END_CODE   = {DATA_W{1'b1}},
    parameter logic [ADDR_W-1:0] TEST_START = 16'h2000,
    parameter int                NUM_WORDS  = 64,
    parameter int                MAX_CYCLES = 100000,
    parameter int                CNT_W      = 17,
    localparam int               IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int               ERR_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    dm_result_checker_if.slave   dm,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [IDX_W-1:0]     first_err
);
    typedef enum logic [1:0] {S_RUN, S_CHECK, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [ERR_W-1:0] POS_END  = ERR_W'(NUM_WORDS);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [ERR_W-1:0]   pos;      // scan position 0..NUM_WORDS; NUM_WORDS = issue phase over
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   cmp_idx;
    logic               cmp_vld;
    logic               hit, expire, issue, mismatch;
    logic [ERR_W-1:0]   err_nx;

    assign idx      = pos[IDX_W-1:0];
    assign hit      = (state == S_RUN) && (dm.dm_web == 4'hF) &&
                      (dm.dm_addr == END_ADDR) && (dm.dm_di == END_CODE);
    assign expire   = (state == S_RUN) && (cyc_cnt == CNT_LAST);
    assign issue    = (state == S_CHECK) && (pos != POS_END);
    assign mismatch = cmp_vld && (dm.chk_rdata != dm.gold_rdata);
    assign err_nx   = err_cnt + ERR_W'(mismatch);

    assign dm.chk_re    = issue;
    assign dm.chk_addr  = issue ? TEST_START + ADDR_W'(idx) : '0;
    assign dm.gold_addr = issue ? idx : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RUN:   if (hit || expire) state_nx = S_CHECK;
            S_CHECK: if (cmp_vld && !issue) state_nx = S_DONE;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_RUN;
        endcase
        if (clear) state_nx = S_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0; pos <= '0; cmp_idx <= '0; cmp_vld <= 1'b0;
            busy <= 1'b0; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
            err_cnt <= '0; first_err <= '0;
        end else if (clear) begin
            cyc_cnt <= '0; pos <= '0; cmp_idx <= '0; cmp_vld <= 1'b0;
            busy <= 1'b0; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
            err_cnt <= '0; first_err <= '0;
        end else begin
            // watchdog saturates rather than wrapping
            if (state == S_RUN && cyc_cnt != CNT_LAST) cyc_cnt <= cyc_cnt + 1'b1;
            if (expire && !hit) timeout <= 1'b1;
            cmp_vld <= issue;
            if (issue) begin
                pos     <= pos + 1'b1;
                cmp_idx <= idx;
            end
            if (mismatch) begin
                err_cnt <= err_nx;
                if (err_cnt == '0) first_err <= cmp_idx;
            end
            busy <= (state_nx == S_CHECK);
            done <= (state_nx == S_DONE);
            pass <= (state_nx == S_DONE) && (err_nx == '0) && !timeout;
        end
    end
endmodule

// File: tb/tb_dm_result_checker.sv
// Scoreboard bench for dm_result_checker: expected run results are queued when a
// run is triggered and checked when done rises.
module tb_dm_result_checker;
    localparam int AW = 16, DW = 32, NW = 64, IW = 6, EW = 7, MAXC = 200;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;

    dm_result_checker_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) bus ();

    logic          busy, done, pass, timeout;
    logic [EW-1:0] err_cnt;
    logic [IW-1:0] first_err;

    dm_result_checker #(.NUM_WORDS(NW), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .clear(clear), .dm(bus.slave),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err(first_err)
    );

    typedef struct { int err; int first; bit pass; bit to; int busy_cyc; } exp_t;
    exp_t sb[$];

    logic [DW-1:0] dm_mem [NW];
    logic [DW-1:0] gold   [NW];
    logic [AW-1:0] rd_off;
    assign rd_off = bus.chk_addr - 16'h2000;

    // 1-cycle-latency DM check port and golden ROM
    always @(posedge clk) begin
        bus.chk_rdata  <= dm_mem[rd_off[IW-1:0]];
        bus.gold_rdata <= gold[bus.gold_addr];
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic dm_write(input logic [3:0] web, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dm_web = web; bus.dm_addr = a; bus.dm_di = d;
        @(negedge clk);
        bus.dm_web = 4'h0; bus.dm_addr = '0; bus.dm_di = '0;
    endtask

    task automatic sentinel(input int err, input int first, input bit ps, input bit to);
        exp_t e;
        e.err = err; e.first = first; e.pass = ps; e.to = to; e.busy_cyc = NW + 1;
        sb.push_back(e);
        dm_write(4'hF, 16'h3fff, 32'hffff_ffff);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   bc = 0, n = 0;
        exp_t e;
        while (!done && n < 2000) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk({tag, "_done_to"}, 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_busy"},  bc, e.busy_cyc);
        chk({tag, "_err"},   err_cnt, e.err);
        chk({tag, "_first"}, first_err, e.first);
        chk({tag, "_pass"},  pass, e.pass);
        chk({tag, "_tmo"},   timeout, e.to);
        chk({tag, "_re0"},   bus.chk_re, 1'b0);
    endtask

    task automatic restore_dm();
        for (int i = 0; i < NW; i++) dm_mem[i] = gold[i];
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(bus.chk_re && bus.gold_addr == IW'(k)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idx_wait_to", 32'd0, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);     chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);     chk({tag, "_tmo"}, timeout, 0);
        chk({tag, "_err"}, err_cnt, 0);   chk({tag, "_first"}, first_err, 0);
        chk({tag, "_re"}, bus.chk_re, 0); chk({tag, "_caddr"}, bus.chk_addr, 0);
        chk({tag, "_gaddr"}, bus.gold_addr, 0);
    endtask

    initial begin
        int k;
        bus.dm_web = 4'h0; bus.dm_addr = '0; bus.dm_di = '0;
        for (int i = 0; i < NW; i++) gold[i] = $urandom;
        restore_dm();
        #1 chk_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1: clean DM, sentinel at cycle 50
        repeat (49) @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        sentinel(0, 0, 1, 0);
        wait_done("t1");
        // second sentinel in DONE is ignored
        dm_write(4'hF, 16'h3fff, 32'hffff_ffff);
        repeat (2) @(negedge clk);
        chk("t1_hold_done", done, 1);
        chk("t1_hold_busy", busy, 0);
        chk("t1_hold_pass", pass, 1);

        // 2: two corrupted words
        do_clear();
        chk("t2_clr_done", done, 0);
        dm_mem[3] = gold[3] ^ 32'h1;
        dm_mem[40] = ~gold[40];
        sentinel(2, 3, 0, 0);
        wait_done("t2");

        // 3: no sentinel -> watchdog after MAXC cycles
        restore_dm();
        do_clear();
        k = 0;
        while (!busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t3_wd_lat", k, MAXC);
        begin
            exp_t e;
            e.err = 0; e.first = 0; e.pass = 0; e.to = 1; e.busy_cyc = NW + 1;
            sb.push_back(e);
        end
        wait_done("t3");

        // 4: partial / wrong-data / wrong-address writes do not trigger
        do_clear();
        dm_write(4'h3, 16'h3fff, 32'hffff_ffff);
        dm_write(4'hF, 16'h3fff, 32'h0);
        dm_write(4'hF, 16'h3ffe, 32'hffff_ffff);
        repeat (3) @(negedge clk);
        chk("t4_no_trig", busy, 0);
        sentinel(0, 0, 1, 0);
        wait_done("t4");

        // 5: clear mid-scan discards partial errors
        do_clear();
        dm_mem[2] = gold[2] + 32'd7;
        dm_write(4'hF, 16'h3fff, 32'hffff_ffff);
        wait_idx(10);
        chk("t5_part_err", err_cnt, 1);
        chk("t5_caddr", bus.chk_addr, 16'h200a);
        do_clear();
        chk("t5_clr_busy", busy, 0);
        chk("t5_clr_err", err_cnt, 0);
        restore_dm();
        sentinel(0, 0, 1, 0);
        wait_done("t5");

        // 6: async reset mid-scan
        do_clear();
        dm_mem[5] = ~gold[5];
        dm_write(4'hF, 16'h3fff, 32'hffff_ffff);
        wait_idx(20);
        chk("t6_busy_pre", busy, 1);
        #2 rst = 1'b0;
        #1 chk_zero("t6_arst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rec_busy", busy, 0);
        restore_dm();
        sentinel(0, 0, 1, 0);
        wait_done("t6");

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
